alu_writeback: RTL

- Result commit stage directly downstream of the 8-bit ALU.
- Captures the ALU result byte, the optional second result byte and the updated PSW.
- Commits them to the ACC, B and PSW architectural registers or to external IRAM/SFR space over a request/acknowledge port.
- Recomputes the parity flag whenever ACC changes and signals completion to the control unit.

---
 rtl/alu_writeback_pkg.sv | 49 ++++
 rtl/alu_writeback_if.sv | 27 ++
 rtl/alu_writeback_parity_gen.sv | 7 +
 rtl/alu_writeback.sv | 103 ++++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared encodings for the ALU result commit stage: destination selects,
// FSM states, direct SFR addresses and the destination decoder.
package alu_writeback_pkg;

  localparam logic [7:0] ACC_ADDR = 8'hE0;
  localparam logic [7:0] B_ADDR   = 8'hF0;
  localparam logic [7:0] PSW_ADDR = 8'hD0;

  typedef enum logic [1:0] {
    DEST_ACC = 2'b00,
    DEST_B   = 2'b01,
    DEST_DIR = 2'b10,
    DEST_PSW = 2'b11
  } dest_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    MEM_REQ = 2'd2,
    WR_HI   = 2'd3
  } state_e;

  // Resolved commit target; direct addresses that hit an SFR fold onto it.
  typedef enum logic [2:0] {
    TGT_ACC  = 3'd0,
    TGT_B    = 3'd1,
    TGT_PSW  = 3'd2,
    TGT_NONE = 3'd3,
    TGT_MEM  = 3'd4
  } tgt_e;

  function automatic tgt_e decode_dest(dest_e sel, logic [7:0] addr);
    tgt_e t;
    t = TGT_NONE;
    case (sel)
      DEST_ACC: t = TGT_ACC;
      DEST_B:   t = TGT_B;
      DEST_DIR: begin
        if      (addr == ACC_ADDR) t = TGT_ACC;
        else if (addr == B_ADDR)   t = TGT_B;
        else if (addr == PSW_ADDR) t = TGT_PSW;
        else                       t = TGT_MEM;
      end
      default:  t = TGT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Result handshake from the ALU plus the external IRAM/SFR write port.
interface alu_writeback_if;
  import alu_writeback_pkg::*;

  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] ans;
  logic [7:0] ans_hi;
  logic [7:0] psw_in;
  dest_e      dest_sel;
  logic [7:0] dest_addr;
  logic       dual_wr;
  logic       mem_wr_req;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       mem_wr_ack;

  modport master (
    output wb_valid, ans, ans_hi, psw_in, dest_sel, dest_addr, dual_wr, mem_wr_ack,
    input  wb_ready, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  wb_valid, ans, ans_hi, psw_in, dest_sel, dest_addr, dual_wr, mem_wr_ack,
    output wb_ready, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/alu_writeback_parity_gen.sv
// Even-parity flag: XOR reduction of the byte about to sit in ACC.
module parity_gen (
  input  logic [7:0] d,
  output logic       p
);
  assign p = ^d;
endmodule

// File: rtl/alu_writeback.sv
// ALU result commit stage: writes ACC/B/PSW or forwards to external memory,
// keeps PSW.P coherent with ACC and pulses done on completion.
module alu_writeback
  import alu_writeback_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_writeback_if.slave  bus,
  output logic [7:0]      acc,
  output logic [7:0]      b_reg,
  output logic [7:0]      psw,
  output logic            done
);

  state_e     state, state_nxt;
  tgt_e       tgt_q, tgt_in;
  logic [7:0] ans_q, ans_hi_q;
  logic [6:0] flags_q, flags_nxt;
  logic       dual_q;
  logic [7:0] acc_nxt, b_nxt;
  logic       p_nxt;
  logic       accept;

  assign bus.wb_ready = (state == IDLE);
  assign accept       = (state == IDLE) && bus.wb_valid;
  assign tgt_in       = decode_dest(bus.dest_sel, bus.dest_addr);

  // P follows the next ACC value so it never lags an ACC update.
  parity_gen u_par (.d(acc_nxt), .p(p_nxt));

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    b_nxt     = b_reg;
    flags_nxt = psw[7:1];
    done      = 1'b0;
    case (state)
      IDLE: if (bus.wb_valid) state_nxt = (tgt_in == TGT_MEM) ? MEM_REQ : COMMIT;
      COMMIT: begin
        flags_nxt = flags_q;
        case (tgt_q)
          TGT_ACC: acc_nxt   = ans_q;
          TGT_B:   b_nxt     = ans_q;
          TGT_PSW: flags_nxt = ans_q[7:1];
          default: ;
        endcase
        if (dual_q) state_nxt = WR_HI;
        else begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      MEM_REQ: if (bus.mem_wr_ack) begin
        flags_nxt = flags_q;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      WR_HI: begin
        b_nxt     = ans_hi_q;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tgt_q           <= TGT_NONE;
      ans_q           <= '0;
      ans_hi_q        <= '0;
      flags_q         <= '0;
      dual_q          <= 1'b0;
      acc             <= '0;
      b_reg           <= '0;
      psw             <= '0;
      bus.mem_wr_req  <= 1'b0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      b_reg <= b_nxt;
      psw   <= {flags_nxt, p_nxt};
      if (accept) begin
        tgt_q    <= tgt_in;
        ans_q    <= bus.ans;
        ans_hi_q <= bus.ans_hi;
        flags_q  <= bus.psw_in[7:1];
        // The high byte only has meaning for MUL/DIV results landing in ACC.
        dual_q   <= bus.dual_wr && (bus.dest_sel == DEST_ACC);
        if (tgt_in == TGT_MEM) begin
          bus.mem_wr_req  <= 1'b1;
          bus.mem_wr_addr <= bus.dest_addr;
          bus.mem_wr_data <= bus.ans;
        end
      end
      if (state == MEM_REQ && bus.mem_wr_ack) bus.mem_wr_req <= 1'b0;
    end
  end

endmodule
